cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_pkg.sv | 18 +
 rtl/rgb565_to_rgb332.sv | 14 +
 rtl/cam_capture.sv | 140 ++++++++++++++
 tb/tb_cam_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared camera geometry, widths and capture FSM encoding
package cam_pkg;

  localparam int H_PIX    = 160;
  localparam int V_LINES  = 120;
  localparam int FB_DEPTH = H_PIX * V_LINES;
  localparam int ADDR_W   = 15;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    WAIT_FR = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } cap_state_t;

endpackage

// File: rtl/rgb565_to_rgb332.sv
// rtl/rgb565_to_rgb332.sv - truncating RGB565 to RGB332 colour reduction
module rgb565_to_rgb332 (
  input  logic [15:0] i_rgb565,
  output logic [7:0]  o_rgb332
);

  // Low-order channel bits are intentionally dropped by the truncation
  logic w_unused;

  // Keep the top bits of each channel: R[4:2], G[5:3], B[4:3]
  assign o_rgb332 = {i_rgb565[15:13], i_rgb565[10:8], i_rgb565[4:3]};
  assign w_unused = ^{i_rgb565[12:11], i_rgb565[7:5], i_rgb565[2:0]};

endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - frame grabber from an 8-bit RGB565 camera into an RGB332 frame buffer
module cam_capture #(
  parameter int H_PIX    = cam_pkg::H_PIX,
  parameter int V_LINES  = cam_pkg::V_LINES,
  parameter int FB_DEPTH = cam_pkg::FB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [7:0]                 px_data,
  output logic [cam_pkg::ADDR_W-1:0] mem_addr,
  output logic [7:0]                 mem_data,
  output logic                       mem_we,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  import cam_pkg::*;

  // Never address past either the sensor geometry or the buffer itself
  localparam int LIMIT = (FB_DEPTH < H_PIX * V_LINES) ? FB_DEPTH : H_PIX * V_LINES;
  localparam logic [CNT_W-1:0]  C_LIMIT = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(LIMIT - 1);

  cap_state_t        r_state;
  logic              r_vs_prev;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic              r_pix_vld;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_vs_rise;
  logic [7:0]        w_pix;
  logic [CNT_W-1:0]  w_cnt_final;

  rgb565_to_rgb332 u_conv (
    .i_rgb565 ({r_hi, px_data}),
    .o_rgb332 (w_pix)
  );

  assign w_vs_rise   = vsync & ~r_vs_prev;
  // A pixel formed on the previous edge has not reached the counter yet
  assign w_cnt_final = r_pix_cnt + {{(CNT_W-1){1'b0}}, r_pix_vld};

  assign mem_addr = r_addr;
  assign mem_data = r_data;
  assign mem_we   = r_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

  // Capture FSM: frame sync, byte pairing, write strobe and address/count bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_vs_prev <= 1'b0;
      r_phase   <= 1'b0;
      r_hi      <= 8'd0;
      r_pix_vld <= 1'b0;
      r_pix_cnt <= '0;
      r_addr    <= '0;
      r_data    <= 8'd0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_vs_prev <= vsync;
      r_we      <= 1'b0;
      r_pix_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (init) begin
            r_state <= WAIT_VS;
            r_busy  <= 1'b1;
          end
        end
        WAIT_VS: begin
          if (w_vs_rise) r_state <= WAIT_FR;
        end
        WAIT_FR: begin
          if (!vsync) begin
            r_state   <= CAPTURE;
            r_addr    <= '0;
            r_pix_cnt <= '0;
            r_phase   <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_vs_rise) begin
            // Frame end wins over any half-received pixel
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_phase <= 1'b0;
            r_err   <= (w_cnt_final != C_DEPTH);
          end else begin
            if (r_pix_vld) begin
              if (r_pix_cnt != '1) r_pix_cnt <= r_pix_cnt + 1'b1;
              if (r_we && (r_addr != C_LAST)) r_addr <= r_addr + 1'b1;
            end
            if (href) begin
              if (!r_phase) begin
                r_hi    <= px_data;
                r_phase <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_data    <= w_pix;
                r_pix_vld <= 1'b1;
                r_we      <= (r_pix_cnt < C_LIMIT);
              end
            end else begin
              r_phase <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!init) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - randomized self-checking bench for cam_capture
module tb_cam_capture;

  localparam int DEPTH = 19200;

  logic        clk = 1'b0;
  logic        rst, init, vsync, href;
  logic [7:0]  px_data;
  logic [14:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we, busy, done, err;

  typedef struct { int addr; int data; } wr_t;
  wr_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pix_total = 0;
  int   n_writes  = 0;
  int   last_addr = -1;
  bit   cmp_on = 1'b0;
  bit   lit_en = 1'b0;
  int   lit_val = 0;

  cam_capture #(.H_PIX(160), .V_LINES(120), .FB_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .vsync    (vsync),
    .href     (href),
    .px_data  (px_data),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int to332(input int hi, input int lo);
    return (hi / 32) * 32 + (hi % 8) * 4 + (lo / 8) % 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes are compared, in order, with what the model says the frame buffer must receive
  always @(negedge clk) begin
    if (cmp_on) begin
      if (mem_we === 1'b1) begin
        wr_t e;
        n_writes++;
        last_addr = int'(mem_addr);
        chk("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_data, e.data);
        end
        if (lit_en) chk("wr_data_literal", mem_data, lit_val);
      end else if (mem_we !== 1'b0) begin
        chk("mem_we_known", mem_we, 0);
      end
    end
  end

  // kind: 0 = F8,00 pattern, 1 = random, 2 = 07,FF pattern
  task automatic send_seg(input int n, input int kind, input bit capt, input int gap);
    int b[$];
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       b.push_back((i % 2 == 0) ? 8'hF8 : 8'h00);
        2:       b.push_back((i % 2 == 0) ? 8'h07 : 8'hFF);
        default: b.push_back(int'($urandom_range(0, 255)));
      endcase
    end
    if (capt) begin
      for (int i = 0; i + 1 < n; i += 2) begin
        if (pix_total < DEPTH) exp_q.push_back('{pix_total, to332(b[i], b[i+1])});
        pix_total++;
      end
    end
    for (int i = 0; i < n; i++) begin
      href    = 1'b1;
      px_data = 8'(b[i]);
      tick();
    end
    href    = 1'b0;
    px_data = 8'($urandom_range(0, 255));
    repeat (gap) tick();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic start_capture();
    init = 1'b1;
    tick();
    pix_total = 0;
    n_writes  = 0;
    last_addr = -1;
    vs_pulse();
  endtask

  task automatic end_frame(input string tag);
    vsync = 1'b1;
    repeat (3) tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, (pix_total != DEPTH) ? 1 : 0);
    chk({tag, "_all_written"}, exp_q.size(), 0);
    vsync = 1'b0;
    href  = 1'b0;
    tick();
  endtask

  initial begin
    int w0;
    rst = 1'b1; init = 1'b0; vsync = 1'b0; href = 1'b0; px_data = 8'h00;
    repeat (3) tick();
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    cmp_on = 1'b1;
    tick();

    // init raised in the middle of an active line: nothing may be written this frame
    vs_pulse();
    send_seg(320, 1, 0, 2);
    href = 1'b1;
    for (int i = 0; i < 60; i++) begin
      px_data = 8'($urandom_range(0, 255));
      if (i == 30) init = 1'b1;
      tick();
    end
    href = 1'b0;
    tick();
    chk("midframe_busy", busy, 1);
    send_seg(320, 1, 0, 2);
    send_seg(320, 1, 0, 2);
    chk("midframe_no_write", n_writes, 0);
    pix_total = 0;
    vs_pulse();

    // Abort after the 5000th pixel has been written
    for (int l = 0; l < 31; l++) send_seg(320, 1, 1, 1);
    send_seg(80, 1, 1, 0);
    rst  = 1'b1;
    init = 1'b0;
    tick();
    exp_q.delete();
    chk("abort_writes", n_writes, 5000);
    chk("abort_we", mem_we, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    tick();

    // Full clean frame of 0xF8,0x00 pairs
    start_capture();
    lit_en = 1'b1; lit_val = 8'hE0;
    for (int l = 0; l < 120; l++) send_seg(320, 0, 1, 1);
    lit_en = 1'b0;
    end_frame("full");
    chk("full_writes", n_writes, 19200);
    chk("full_last_addr", last_addr, 19199);
    chk("full_err_literal", err, 0);

    // init held after completion: no restart
    vs_pulse();
    send_seg(320, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
      tick();
    end
    init = 1'b0;
    repeat (2) tick();
    chk("release_done", done, 0);
    chk("release_busy", busy, 0);
    chk("release_err_kept", err, 0);

    // 121 lines: buffer fills, further pixels dropped
    start_capture();
    for (int l = 0; l < 121; l++) send_seg(320, 1, 1, 1);
    end_frame("ovf");
    chk("ovf_writes", n_writes, 19200);
    chk("ovf_last_addr", last_addr, 19199);
    chk("ovf_err_literal", err, 1);
    init = 1'b0;
    repeat (2) tick();

    // Short frame with an odd-length line and a pixel cut by vsync
    start_capture();
    send_seg(320, 1, 1, 1);
    w0 = n_writes;
    lit_en = 1'b1; lit_val = 8'h1F;
    send_seg(321, 2, 1, 2);
    lit_en = 1'b0;
    chk("odd_line_writes", n_writes - w0, 160);
    send_seg(320, 1, 1, 1);
    href = 1'b1;
    px_data = 8'($urandom_range(0, 255));
    tick();
    px_data = 8'($urandom_range(0, 255));
    end_frame("short");
    chk("short_err_literal", err, 1);
    chk("short_writes", n_writes, 480);
    init = 1'b0;
    repeat (3) tick();
    chk("final_idle_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
